// File: rtl/vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_reader
// Description : Scan-out engine for a 320x240 RGB565 frame buffer. Generates
//               640x480@60 VGA timing from the system clock, addresses the
//               buffer with 2x2 pixel doubling, converts RGB565 to 12-bit
//               VGA colour and keeps sync/active aligned with that colour.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_reader #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 320
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [16:0] read_addr,
  input  logic [15:0] fb_pixel,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Widths leave room for the exclusive end-of-sync bounds.
  localparam int TW = $clog2(CLK_DIV);
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [16:0]   ROW_STEP  = 17'(FB_W);

  logic [TW-1:0] r_tick;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  // Buffer address of column 0 on the current line: (v>>1)*FB_W.
  logic [16:0]   r_row_base;

  logic          w_period_end;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic [16:0]   w_row_base_next;
  logic          w_next_active;
  logic [16:0]   w_next_addr;
  logic          w_cur_active;
  logic          w_cur_hsync;
  logic          w_cur_vsync;
  logic          w_unused_bits;

  // Low-order colour bits are dropped by the 565 -> 444 conversion.
  assign w_unused_bits = ^{fb_pixel[11], fb_pixel[6:5], fb_pixel[0]};

  assign w_period_end = (r_tick == TICK_LAST);
  assign w_h_wrap     = (r_h == H_LAST);
  assign w_v_wrap     = (r_v == V_LAST);

  // Position and row base that the counters take at the next period boundary.
  always_comb begin
    w_h_next        = r_h;
    w_v_next        = r_v;
    w_row_base_next = r_row_base;
    if (w_h_wrap) begin
      w_h_next = '0;
      if (w_v_wrap) begin
        w_v_next        = '0;
        w_row_base_next = '0;
      end else begin
        w_v_next = r_v + 1'b1;
        // Leaving an odd line moves to the next stored row.
        if (r_v[0]) begin
          w_row_base_next = r_row_base + ROW_STEP;
        end
      end
    end else begin
      w_h_next = r_h + 1'b1;
    end
  end

  // Address for the upcoming pixel period; zero throughout blanking.
  always_comb begin
    w_next_active = (w_h_next < H_ACT) && (w_v_next < V_ACT);
    w_next_addr   = '0;
    if (w_next_active) begin
      w_next_addr = w_row_base_next + 17'(w_h_next >> 1);
    end
  end

  // Decode of the period currently being scanned.
  always_comb begin
    w_cur_active = (r_h < H_ACT) && (r_v < V_ACT);
    w_cur_hsync  = !((r_h >= HS_START) && (r_h < HS_END));
    w_cur_vsync  = !((r_v >= VS_START) && (r_v < VS_END));
  end

  // Pixel tick, raster counters and registered read address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick     <= '0;
      r_h        <= '0;
      r_v        <= '0;
      r_row_base <= '0;
      read_addr  <= '0;
    end else begin
      r_tick <= w_period_end ? '0 : r_tick + 1'b1;
      if (w_period_end) begin
        r_h        <= w_h_next;
        r_v        <= w_v_next;
        r_row_base <= w_row_base_next;
        read_addr  <= w_next_addr;
      end
    end
  end

  // Output stage: colour of the ending period plus its sync/active, loaded together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      active <= 1'b0;
    end else if (w_period_end) begin
      vga_r  <= w_cur_active ? fb_pixel[15:12] : 4'h0;
      vga_g  <= w_cur_active ? fb_pixel[10:7]  : 4'h0;
      vga_b  <= w_cur_active ? fb_pixel[4:1]   : 4'h0;
      hsync  <= w_cur_hsync;
      vsync  <= w_cur_vsync;
      active <= w_cur_active;
    end
  end

  // One-clock pulse on the wrap into the first pixel of a new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_period_end && w_h_wrap && w_v_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_reader
// Description : Self-checking bench for vga_fb_reader on a scaled-down raster,
//               with a 1-clk RAM model and a position-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_reader;

  localparam int CD    = 4;
  localparam int HA    = 16;
  localparam int HFP   = 2;
  localparam int HS    = 4;
  localparam int HBP   = 2;
  localparam int VA    = 12;
  localparam int VFP   = 1;
  localparam int VS    = 2;
  localparam int VBP   = 2;
  localparam int FBW   = 8;
  localparam int HT    = HA + HFP + HS + HBP;
  localparam int VT    = VA + VFP + VS + VBP;
  localparam int LINE  = HT * CD;
  localparam int FRAME = VT * LINE;
  localparam int MEMN  = FBW * (VA / 2);

  typedef struct packed {
    logic [16:0] addr;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] read_addr;
  logic [15:0] fb_pixel;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, active, frame_start;

  logic [15:0] mem [0:MEMN-1];
  int n;
  int checks = 0;
  int errors = 0;

  vga_fb_reader #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FB_W(FBW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .fb_pixel(fb_pixel),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync),
    .vsync(vsync), .active(active), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame buffer read port: one clock of latency.
  always @(posedge clk) begin
    fb_pixel <= (int'(read_addr) < MEMN) ? mem[read_addr] : 16'hDEAD;
  end

  function automatic int addr_of(int h, int v);
    return (h < HA && v < VA) ? (v / 2) * FBW + h / 2 : 0;
  endfunction

  // Expected outputs n clocks after reset release, from raster position alone.
  function automatic exp_t model(int cyc);
    exp_t e;
    int p, h, v, q, hq, vq;
    logic [15:0] pix;
    p = cyc / CD;
    h = p % HT;
    v = (p / HT) % VT;
    e.addr = 17'(addr_of(h, v));
    e.fs   = (cyc > 0 && cyc % FRAME == 0) ? 1'b1 : 1'b0;
    if (p == 0) begin
      e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
      e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0;
    end else begin
      q  = p - 1;
      hq = q % HT;
      vq = (q / HT) % VT;
      e.act = (hq < HA && vq < VA) ? 1'b1 : 1'b0;
      pix   = e.act ? mem[addr_of(hq, vq)] : 16'h0000;
      e.r   = pix[15:12];
      e.g   = pix[10:7];
      e.b   = pix[4:1];
      e.hs  = (hq >= HA + HFP && hq < HA + HFP + HS) ? 1'b0 : 1'b1;
      e.vs  = (vq >= VA + VFP && vq < VA + VFP + VS) ? 1'b0 : 1'b1;
    end
    return e;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < MEMN; i++) mem[i] = 16'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic hold_reset(int k);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic test_reset();
    fill_mem();
    mem[0] = 16'hFFFF;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({read_addr, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start} !==
          {17'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_values cyc=%0d got addr=%0d rgb=%h%h%h hs=%b vs=%b act=%b fs=%b required addr=0 rgb=000 hs=1 vs=1 act=0 fs=0",
                 i, read_addr, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start);
      end
    end
  endtask

  task automatic test_address_map();
    exp_t e;
    logic [16:0] prev;
    fill_mem();
    hold_reset(2);
    release_reset();
    prev = read_addr;
    while (n < FRAME + LINE) begin
      e = model(n);
      checks++;
      if (read_addr !== e.addr) begin
        errors++;
        $display("FAIL addr_map n=%0d got %0d required %0d", n, read_addr, e.addr);
      end
      if (n == 2 * HT * CD) begin
        checks++;
        if (read_addr !== 17'(FBW)) begin
          errors++;
          $display("FAIL addr_line2_start got %0d required %0d", read_addr, FBW);
        end
      end
      if (n == ((VA - 1) * HT + HA - 1) * CD) begin
        checks++;
        if (read_addr !== 17'(MEMN - 1)) begin
          errors++;
          $display("FAIL addr_last_pixel got %0d required %0d", read_addr, MEMN - 1);
        end
      end
      checks++;
      if (read_addr !== prev && (n % CD) != 0) begin
        errors++;
        $display("FAIL addr_change_tick n=%0d got change at tick %0d required tick 0", n, n % CD);
      end
      prev = read_addr;
      step();
    end
  endtask

  task automatic test_colour();
    exp_t e;
    logic [17:0] prev;
    logic [11:0] want;
    fill_mem();
    mem[0] = 16'hF81F;
    mem[1] = 16'h07E0;
    hold_reset(2);
    release_reset();
    prev = {vga_r, vga_g, vga_b, hsync, vsync, active, frame_start};
    while (n < FRAME + 8) begin
      e = model(n);
      checks++;
      if ({vga_r, vga_g, vga_b, active} !== {e.r, e.g, e.b, e.act}) begin
        errors++;
        $display("FAIL colour n=%0d got rgb=%h%h%h act=%b required rgb=%h%h%h act=%b",
                 n, vga_r, vga_g, vga_b, active, e.r, e.g, e.b, e.act);
      end
      if (n >= CD && n < 5 * CD) begin
        want = (n < 3 * CD) ? 12'hF0F : 12'h0F0;
        checks++;
        if ({vga_r, vga_g, vga_b} !== want) begin
          errors++;
          $display("FAIL colour_first_pixels n=%0d got %h required %h", n, {vga_r, vga_g, vga_b}, want);
        end
      end
      checks++;
      if ({vga_r, vga_g, vga_b, hsync, vsync, active} !== prev[17:1] && (n % CD) != 0) begin
        errors++;
        $display("FAIL output_change_tick n=%0d got change at tick %0d required tick 0", n, n % CD);
      end
      prev = {vga_r, vga_g, vga_b, hsync, vsync, active, frame_start};
      step();
    end
  endtask

  task automatic test_sync();
    exp_t e;
    int act_rise, hs_fall1, hs_fall2, hs_rise1, vs_low, vs_fall1, vs_fall2;
    logic p_act, p_hs, p_vs;
    act_rise = -1; hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
    vs_low = 0; vs_fall1 = -1; vs_fall2 = -1;
    fill_mem();
    hold_reset(2);
    release_reset();
    p_act = active; p_hs = hsync; p_vs = vsync;
    while (n < 2 * FRAME + 2 * LINE) begin
      e = model(n);
      checks++;
      if ({hsync, vsync} !== {e.hs, e.vs}) begin
        errors++;
        $display("FAIL sync n=%0d got hs=%b vs=%b required hs=%b vs=%b", n, hsync, vsync, e.hs, e.vs);
      end
      if (active && !p_act && act_rise < 0) act_rise = n;
      if (!hsync && p_hs) begin
        if (hs_fall1 < 0) hs_fall1 = n;
        else if (hs_fall2 < 0) hs_fall2 = n;
      end
      if (hsync && !p_hs && hs_rise1 < 0 && hs_fall1 >= 0) hs_rise1 = n;
      if (!vsync && p_vs) begin
        if (vs_fall1 < 0) vs_fall1 = n;
        else if (vs_fall2 < 0) vs_fall2 = n;
      end
      if (!vsync && n < FRAME + CD) vs_low++;
      p_act = active; p_hs = hsync; p_vs = vsync;
      step();
    end
    checks++;
    if (hs_fall1 - act_rise != (HA + HFP) * CD || act_rise < 0 || hs_fall1 < 0) begin
      errors++;
      $display("FAIL hsync_offset got %0d required %0d", hs_fall1 - act_rise, (HA + HFP) * CD);
    end
    checks++;
    if (hs_rise1 - hs_fall1 != HS * CD || hs_rise1 < 0) begin
      errors++;
      $display("FAIL hsync_width got %0d required %0d", hs_rise1 - hs_fall1, HS * CD);
    end
    checks++;
    if (hs_fall2 - hs_fall1 != LINE || hs_fall2 < 0) begin
      errors++;
      $display("FAIL line_length got %0d required %0d", hs_fall2 - hs_fall1, LINE);
    end
    checks++;
    if (vs_low != VS * LINE) begin
      errors++;
      $display("FAIL vsync_width got %0d required %0d", vs_low, VS * LINE);
    end
    checks++;
    if (vs_fall2 - vs_fall1 != FRAME || vs_fall2 < 0) begin
      errors++;
      $display("FAIL frame_length got %0d required %0d", vs_fall2 - vs_fall1, FRAME);
    end
  endtask

  task automatic test_frame_start();
    exp_t e;
    int pulses;
    pulses = 0;
    hold_reset(1);
    release_reset();
    while (n < 3 * FRAME + 10) begin
      e = model(n);
      checks++;
      if (frame_start !== e.fs) begin
        errors++;
        $display("FAIL frame_start n=%0d got %b required %b", n, frame_start, e.fs);
      end
      if (frame_start === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL frame_start_count got %0d required 3", pulses);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int target;
    target = (8 * HT + 5) * CD;
    fill_mem();
    hold_reset(1);
    release_reset();
    while (n < target) begin
      e = model(n);
      checks++;
      if ({read_addr, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start} !== e) begin
        errors++;
        $display("FAIL pre_reset_run n=%0d got %h required %h",
                 n, {read_addr, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start}, e);
      end
      step();
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({read_addr, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start} !==
          {17'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL mid_reset_values cyc=%0d got addr=%0d rgb=%h%h%h hs=%b vs=%b act=%b fs=%b required reset values",
                 i, read_addr, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start);
      end
    end
    rst_n = 1'b1;
    n = 0;
    while (n <= FRAME + 2) begin
      e = model(n);
      checks++;
      if ({read_addr, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start} !== e) begin
        errors++;
        $display("FAIL post_reset_run n=%0d got %h required %h",
                 n, {read_addr, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start}, e);
      end
      step();
    end
  endtask

  initial begin
    n = 0;
    test_reset();
    test_address_map();
    test_colour();
    test_sync();
    test_frame_start();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
